imem_loader: RTL and testbench

//  Upstream boot stage for the 8-bit core: receives a program image as a byte stream and

---
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: parses SYNC/N/words/CSUM byte frames into instruction RAM writes
// and holds the core in reset until a checksum-valid image has been loaded.
module imem_loader #(
  parameter int          ADDR_W = 6,
  parameter int          INSN_W = 18,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INSN_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);
  localparam int         HI_W  = INSN_W - 16;
  localparam logic [8:0] DEPTH = 9'(2**ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT, S_B0, S_B1, S_B2, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [8:0]          n_q, n_d, cnt_q, cnt_d;
  logic [7:0]          csum_q, csum_d, mid_q, mid_d;
  logic [HI_W-1:0]     hi_q, hi_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [INSN_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                cpu_rst_q, cpu_rst_d, done_q, done_d, err_q, err_d;
  logic                acc;

  assign rx_ready   = ~rst & ~we_q;
  assign acc        = rx_valid & rx_ready;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      cnt_q     <= '0;
      csum_q    <= '0;
      mid_q     <= '0;
      hi_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      csum_q    <= csum_d;
      mid_q     <= mid_d;
      hi_q      <= hi_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    mid_d   = mid_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    // Advance after each write but saturate so a full image never wraps to 0.
    if (we_q && addr_q != '1) addr_d = addr_q + 1'b1;
    if (acc) begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (rx_data == SYNC) begin
            state_d = S_CNT;
            csum_d  = '0;
          end
        end
        S_CNT: begin
          if (rx_data == 8'd0 || {1'b0, rx_data} > DEPTH) begin
            state_d = S_ERR;
          end else begin
            n_d     = {1'b0, rx_data};
            cnt_d   = '0;
            csum_d  = rx_data;
            addr_d  = '0;
            state_d = S_B0;
          end
        end
        S_B0: begin
          if (rx_data[7:HI_W] != '0) begin
            state_d = S_ERR;
          end else begin
            hi_d    = rx_data[HI_W-1:0];
            csum_d  = csum_q + rx_data;
            state_d = S_B1;
          end
        end
        S_B1: begin
          mid_d   = rx_data;
          csum_d  = csum_q + rx_data;
          state_d = S_B2;
        end
        S_B2: begin
          csum_d  = csum_q + rx_data;
          wdata_d = {hi_q, mid_q, rx_data};
          we_d    = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q + 1'b1 == n_q) ? S_CSUM : S_B0;
        end
        S_CSUM:  state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_rst_d = (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
  end
endmodule

// File: tb/tb_imem_loader.sv
// Randomised frame-level bench for imem_loader: a frame model predicts the RAM
// writes and final done/err status, which are compared with what the DUT produced.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, imem_we, cpu_rst, done, err;
  logic [5:0]  imem_addr;
  logic [17:0] imem_wdata;

  int checks = 0;
  int errors = 0;

  logic [7:0]  frm[$];
  int          exp_a[$];
  logic [17:0] exp_d[$];
  bit          exp_done, exp_err;
  int          wr_a[$];
  logic [17:0] wr_d[$];
  bit          wr_ok[$];
  bit          prev_hs = 1'b0;

  imem_loader dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Record every write; it must follow a handshake edge and drop rx_ready.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_a.push_back(int'(imem_addr));
      wr_d.push_back(imem_wdata);
      wr_ok.push_back(prev_hs && !rx_ready);
    end
    prev_hs = rx_valid && rx_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] csum_of(input int n);
    int s = 0;
    for (int i = 1; i <= 3 * n + 1; i++) s += int'(frm[i]);
    return 8'(s);
  endfunction

  // Frame-level reference: which words land in RAM and how the frame ends.
  task automatic model();
    int n, s;
    logic [7:0] b0, b1, b2;
    exp_a.delete(); exp_d.delete();
    exp_done = 1'b0; exp_err = 1'b1;
    n = int'(frm[1]);
    if (n == 0 || n > 64) return;
    s = n;
    for (int k = 0; k < n; k++) begin
      b0 = frm[2+3*k]; b1 = frm[3+3*k]; b2 = frm[4+3*k];
      if (b0 > 8'd3) return;
      exp_a.push_back(k);
      exp_d.push_back({b0[1:0], b1, b2});
      s += int'(b0) + int'(b1) + int'(b2);
    end
    if (frm[2+3*n] == 8'(s)) begin exp_done = 1'b1; exp_err = 1'b0; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    rx_valid = 1'b1; rx_data = b;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (rx_ready) got = 1'b1;
      else @(posedge clk);
    end
    chk("handshake", 32'(got), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int from, input string tag);
    wr_a.delete(); wr_d.delete(); wr_ok.delete();
    model();
    for (int i = from; i < frm.size(); i++) send_byte(frm[i]);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_nwr"}, 32'(wr_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < wr_a.size() && i < exp_a.size(); i++) begin
      chk({tag, "_addr"}, 32'(wr_a[i]), 32'(exp_a[i]));
      chk({tag, "_data"}, 32'(wr_d[i]), 32'(exp_d[i]));
      chk({tag, "_lat"},  32'(wr_ok[i]), 32'd1);
    end
    chk({tag, "_done"},    32'(done),    32'(exp_done));
    chk({tag, "_err"},     32'(err),     32'(exp_err));
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!exp_done));
  endtask

  task automatic gen_frame(input int n, input bit bad_csum, input int bad_word);
    logic [7:0] b0;
    frm.delete();
    frm.push_back(8'hA5); frm.push_back(8'(n));
    for (int k = 0; k < n; k++) begin
      b0 = (k == bad_word) ? 8'(4 << $urandom_range(0, 5)) : 8'($urandom_range(0, 3));
      frm.push_back(b0);
      if (k == bad_word) begin
        repeat (3) frm.push_back(8'h00);
        return;
      end
      frm.push_back(8'($urandom)); frm.push_back(8'($urandom));
    end
    frm.push_back(csum_of(n) + 8'(bad_csum));
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_cpu_rst",  32'(cpu_rst),  32'd1);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err",      32'(err),      32'd0);
    chk("rst_we",       32'(imem_we),  32'd0);
    chk("rst_addr",     32'(imem_addr), 32'd0);
    chk("rst_wdata",    32'(imem_wdata), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two-word frame, correct then corrupted checksum
    frm = '{8'hA5, 8'h02, 8'h00, 8'h12, 8'h34, 8'h03, 8'hFF, 8'h01};
    frm.push_back(csum_of(2));
    send_frame(0, "t1");
    frm[8] = frm[8] + 8'd1;
    send_frame(0, "t2");

    // Count out of range, then recovery via SYNC
    frm = '{8'hA5, 8'h00};
    send_frame(0, "t3_n0");
    frm = '{8'hA5, 8'h41};
    send_frame(0, "t3_n65");
    frm = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h07};
    frm.push_back(csum_of(1));
    send_byte(frm[0]);
    chk("t3_err_clr", 32'(err), 32'd0);
    send_frame(1, "t3_tail");

    // Bad b0 aborts immediately; trailing bytes are ignored
    frm = '{8'hA5, 8'h01, 8'h04, 8'h11, 8'h22};
    send_frame(0, "t4");

    // Full 64-word image
    frm = '{8'hA5, 8'h40};
    for (int k = 0; k < 64; k++) begin
      frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'(k));
    end
    frm.push_back(csum_of(64));
    send_frame(0, "t5");

    // Reset in the middle of word 3
    gen_frame(5, 1'b0, -1);
    model();
    wr_a.delete(); wr_d.delete(); wr_ok.delete();
    for (int i = 0; i < 12; i++) send_byte(frm[i]);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rdy_in_rst", 32'(rx_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_we",      32'(imem_we),    32'd0);
    chk("t6_addr",    32'(imem_addr),  32'd0);
    chk("t6_wdata",   32'(imem_wdata), 32'd0);
    chk("t6_cpu_rst", 32'(cpu_rst),    32'd1);
    chk("t6_done",    32'(done),       32'd0);
    chk("t6_err",     32'(err),        32'd0);
    send_byte(8'h12);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_nwr", 32'(wr_a.size()), 32'd3);
    for (int i = 0; i < 3 && i < wr_a.size(); i++)
      chk("t6_data", 32'(wr_d[i]), 32'(exp_d[i]));
    chk("t6_idle_err",  32'(err),  32'd0);
    chk("t6_idle_done", 32'(done), 32'd0);
    gen_frame(4, 1'b0, -1);
    send_frame(0, "t6_new");

    // Random frames: random size, occasional bad checksum or bad b0
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 64);
      gen_frame(n, ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1);
      send_frame(0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
